sap_controller: RTL

- Controller-sequencer for the SAP-1 datapath. Replaces the hand-driven control byte with a fetch/execute sequencer.
- Owns the 4-bit program counter (PC), the 8-bit instruction register (IR) and a 6-state ring counter (T1..T6).
- Decodes LDA/ADD/SUB/OUT/HLT into the level control lines consumed by the A/B registers, the ALU, RAM/MAR and the output latch.
- Advances one T-state per qualified step, so the datapath samples the same step the controller advances on.

---
 rtl/sap_pkg.sv | 57 +++++
 rtl/sap_ring_counter.sv | 35 +++
 rtl/sap_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, one-hot T-states,
// control-word bit positions and small opcode classification helpers.
package sap_pkg;

  // Opcodes carried in ir[7:4]
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // One-hot ring states
  localparam int unsigned T_W = 6;
  localparam logic [T_W-1:0] T1 = 6'b000001;
  localparam logic [T_W-1:0] T2 = 6'b000010;
  localparam logic [T_W-1:0] T3 = 6'b000100;
  localparam logic [T_W-1:0] T4 = 6'b001000;
  localparam logic [T_W-1:0] T5 = 6'b010000;
  localparam logic [T_W-1:0] T6 = 6'b100000;

  // Control-word bit indices
  localparam int unsigned CW_BUS_DRIVE  = 0;
  localparam int unsigned CW_MAR_LOAD   = 1;
  localparam int unsigned CW_RAM_OUT    = 2;
  localparam int unsigned CW_A_LATCH    = 3;
  localparam int unsigned CW_A_ENABLE   = 4;
  localparam int unsigned CW_B_LATCH    = 5;
  localparam int unsigned CW_ALU_ENABLE = 6;
  localparam int unsigned CW_ALU_SUB    = 7;
  localparam int unsigned CW_OUT_LATCH  = 8;
  localparam int unsigned CW_W          = 9;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Instructions that fetch an operand from RAM in T4/T5
  function automatic logic is_mem_op(logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Instructions that use the ALU in T6
  function automatic logic is_alu_op(logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Last T-state that does useful work for an opcode; used for early wrap.
  // HLT maps to T4 but never advances out of it.
  function automatic logic [T_W-1:0] last_state(logic [3:0] op);
    if (is_alu_op(op)) begin
      return T6;
    end else if (op == OP_LDA) begin
      return T5;
    end else begin
      return T4;
    end
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot ring counter (T1..T6) with synchronous restart and an
// early-wrap input that sends the ring back to T1 on the next step.
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step,
  input  logic           restart,
  input  logic           last,
  output logic [T_W-1:0] t_q
);

  logic [T_W-1:0] t_d;

  // Next state: restart wins, otherwise rotate (or wrap early) on step
  always_comb begin
    t_d = t_q;
    if (restart) begin
      t_d = T1;
    end else if (step) begin
      t_d = last ? T1 : {t_q[T_W-2:0], t_q[T_W-1]};
    end
  end

  // State register, async reset to T1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= T1;
    end else begin
      t_q <= t_d;
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP-1 fetch/execute sequencer. Owns PC, IR and the T-state ring, and
// decodes the current step into the datapath control lines.
module sap_controller
  import sap_pkg::*;
#(
  parameter int unsigned PC_W     = 4,
  parameter bit          SKIP_NOP = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            step_en,
  input  logic            restart,
  input  logic [7:0]      bus_in,
  output logic [7:0]      bus_out,
  output logic            bus_drive,
  output logic            mar_load,
  output logic            ram_out,
  output logic            a_latch,
  output logic            a_enable,
  output logic            b_latch,
  output logic            alu_enable,
  output logic            alu_sub,
  output logic            out_latch,
  output logic            halted,
  output logic [PC_W-1:0] pc_q,
  output logic [7:0]      ir_q,
  output logic [T_W-1:0]  t_q
);

  logic [3:0] op;
  logic       hlt_now;
  logic       ring_step;
  logic       ring_last;
  ctrl_word_t cw;
  logic [7:0] bus_val;

  assign op = ir_q[7:4];

  // HLT in T4 freezes the ring at T4 while the halt flag is set
  assign hlt_now   = (t_q == T4) && (op == OP_HLT);
  assign ring_step = step_en && !halted && !hlt_now;
  assign ring_last = SKIP_NOP && (t_q == last_state(op));

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (ring_step),
    .restart (restart),
    .last    (ring_last),
    .t_q     (t_q)
  );

  // PC, IR and halt flag: restart clears, otherwise update on qualified steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      ir_q   <= 8'h00;
      halted <= 1'b0;
    end else if (restart) begin
      pc_q   <= '0;
      ir_q   <= 8'h00;
      halted <= 1'b0;
    end else if (step_en && !halted) begin
      if (t_q == T2) begin
        pc_q <= pc_q + PC_W'(1);
      end
      if (t_q == T3) begin
        ir_q <= bus_in;
      end
      if (hlt_now) begin
        halted <= 1'b1;
      end
    end
  end

  // Control decode from (T-state, opcode, halted); halted silences everything
  always_comb begin
    cw      = '0;
    bus_val = 8'h00;
    if (!halted) begin
      unique case (t_q)
        T1: begin
          bus_val                = 8'(pc_q);
          cw[CW_BUS_DRIVE]       = 1'b1;
          cw[CW_MAR_LOAD]        = 1'b1;
        end
        T2: begin
          // PC increment only; bus idle
        end
        T3: begin
          cw[CW_RAM_OUT]         = 1'b1;
        end
        T4: begin
          if (is_mem_op(op)) begin
            bus_val              = {4'h0, ir_q[3:0]};
            cw[CW_BUS_DRIVE]     = 1'b1;
            cw[CW_MAR_LOAD]      = 1'b1;
          end else if (op == OP_OUT) begin
            cw[CW_A_ENABLE]      = 1'b1;
            cw[CW_OUT_LATCH]     = 1'b1;
          end
        end
        T5: begin
          if (op == OP_LDA) begin
            cw[CW_RAM_OUT]       = 1'b1;
            cw[CW_A_LATCH]       = 1'b1;
          end else if (is_alu_op(op)) begin
            cw[CW_RAM_OUT]       = 1'b1;
            cw[CW_B_LATCH]       = 1'b1;
          end
        end
        T6: begin
          if (is_alu_op(op)) begin
            cw[CW_ALU_ENABLE]    = 1'b1;
            cw[CW_A_LATCH]       = 1'b1;
            cw[CW_ALU_SUB]       = (op == OP_SUB);
          end
        end
        default: begin
          cw      = '0;
          bus_val = 8'h00;
        end
      endcase
    end
  end

  // Fan the control word out to the individual lines
  assign bus_out    = bus_val;
  assign bus_drive  = cw[CW_BUS_DRIVE];
  assign mar_load   = cw[CW_MAR_LOAD];
  assign ram_out    = cw[CW_RAM_OUT];
  assign a_latch    = cw[CW_A_LATCH];
  assign a_enable   = cw[CW_A_ENABLE];
  assign b_latch    = cw[CW_B_LATCH];
  assign alu_enable = cw[CW_ALU_ENABLE];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign out_latch  = cw[CW_OUT_LATCH];

endmodule
